// File: rtl/apb_cmd_master_if.sv
// Bundles the command, response and APB request signals of apb_cmd_master.
// The master modport is the requester's view; slave is the environment's view.
interface apb_cmd_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Runs single-word valid/ready commands as APB transfers with an optional
// ACCESS-phase timeout; all outputs come straight from registers.
//
// state  | meaning
// IDLE   | cmd_ready raised, waiting for a command
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready or timeout
// RESP   | response held until rsp_ready
module apb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                   i_pclk,
    input  logic                   i_preset,
    apb_cmd_master_if.master       io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    localparam logic [15:0] LP_TMO    = 16'(TIMEOUT);
    localparam logic        LP_TMO_EN = (TIMEOUT != 0);

    state_t        r_state,       w_state_nxt;
    logic          r_cmd_ready,   w_cmd_ready_nxt;
    logic          r_rsp_valid,   w_rsp_valid_nxt;
    logic [DW-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic          r_rsp_err,     w_rsp_err_nxt;
    logic          r_rsp_timeout, w_rsp_timeout_nxt;
    logic          r_psel,        w_psel_nxt;
    logic          r_penable,     w_penable_nxt;
    logic          r_pwrite,      w_pwrite_nxt;
    logic [AW-1:0] r_paddr,       w_paddr_nxt;
    logic [DW-1:0] r_pwdata,      w_pwdata_nxt;
    logic [15:0]   r_cnt,         w_cnt_nxt;
    logic [15:0]   w_cnt_inc;

    assign w_cnt_inc = r_cnt + 16'd1;

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_pwrite_nxt      = r_pwrite;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_cnt_nxt         = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
                // cmd_ready is raised one cycle after entering IDLE, so acceptance needs it already high
                if (!r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b1;
                end else if (io_bus.cmd_valid) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_pwrite_nxt    = io_bus.cmd_write;
                    w_paddr_nxt     = io_bus.cmd_addr;
                    w_pwdata_nxt    = io_bus.cmd_wdata;
                    w_psel_nxt      = 1'b1;
                    w_state_nxt     = S_SETUP;
                end
            end
            S_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = S_ACCESS;
            end
            S_ACCESS: begin
                if (io_bus.pready) begin
                    w_rsp_rdata_nxt   = (!r_pwrite && !io_bus.pslverr) ? io_bus.prdata : '0;
                    w_rsp_err_nxt     = io_bus.pslverr;
                    w_rsp_timeout_nxt = 1'b0;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else if (LP_TMO_EN && (w_cnt_inc == LP_TMO)) begin
                    w_cnt_nxt         = w_cnt_inc;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RESP: begin
                if (io_bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign io_bus.cmd_ready   = r_cmd_ready;
    assign io_bus.rsp_valid   = r_rsp_valid;
    assign io_bus.rsp_rdata   = r_rsp_rdata;
    assign io_bus.rsp_err     = r_rsp_err;
    assign io_bus.rsp_timeout = r_rsp_timeout;
    assign io_bus.psel        = r_psel;
    assign io_bus.penable     = r_penable;
    assign io_bus.pwrite      = r_pwrite;
    assign io_bus.paddr       = r_paddr;
    assign io_bus.pwdata      = r_pwdata;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed and randomized transfers for apb_cmd_master, checked against a
// transaction-level model of latency, response fields and bus stability.
module tb_apb_cmd_master;
    localparam int TMO = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    apb_cmd_master_if #(.AW(32), .DW(32)) bus ();

    apb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .i_pclk   (clk),
        .i_preset (rst),
        .io_bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer: waits = ACCESS cycles the slave holds pready low,
    // hold = cycles the consumer stalls rsp_ready once the response shows up.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic err, input logic [31:0] rd,
                           input int hold);
        int          edges;
        int          acc;
        int          guard;
        logic        exp_to;
        int          exp_lat;
        int          exp_acc;
        logic [31:0] exp_rd;
        logic        exp_err;
        exp_to  = (waits >= TMO);
        exp_lat = exp_to ? TMO + 2 : waits + 3;
        exp_acc = exp_to ? TMO : waits + 1;
        exp_rd  = (exp_to || wr || err) ? 32'h0 : rd;
        exp_err = exp_to ? 1'b1 : err;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_wait", {31'b0, bus.cmd_ready}, 32'd1);
        if (bus.cmd_ready !== 1'b1) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_write = ~wr;
        edges = 1;
        acc   = 0;
        chk("setup_phase", {29'b0, bus.psel, bus.penable, bus.cmd_ready}, 32'b100);

        while (bus.rsp_valid !== 1'b1 && edges < 60) begin
            chk("penable_needs_psel", {31'b0, bus.penable & ~bus.psel}, 32'd0);
            if (bus.psel === 1'b1) begin
                chk("paddr_stable", bus.paddr, addr);
                chk("pwdata_stable", bus.pwdata, wdata);
                chk("pwrite_stable", {31'b0, bus.pwrite}, {31'b0, wr});
            end
            if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
                acc++;
                bus.pready  = (acc > waits);
                bus.pslverr = bus.pready ? err : 1'($urandom);
                bus.prdata  = bus.pready ? rd : $urandom;
            end else begin
                bus.pready  = 1'($urandom);
                bus.pslverr = 1'($urandom);
                bus.prdata  = $urandom;
            end
            @(negedge clk);
            edges++;
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;

        chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("rsp_latency", edges, exp_lat);
        chk("access_cycles", acc, exp_acc);
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
        chk("rsp_timeout", {31'b0, bus.rsp_timeout}, {31'b0, exp_to});
        chk("bus_idle_in_resp", {30'b0, bus.psel, bus.penable}, 32'd0);

        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("hold_rdata", bus.rsp_rdata, exp_rd);
            chk("hold_flags", {30'b0, bus.rsp_err, bus.rsp_timeout}, {30'b0, exp_err, exp_to});
            chk("hold_no_cmd", {30'b0, bus.cmd_ready, bus.psel}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_dropped", {29'b0, bus.rsp_valid, bus.cmd_ready, bus.psel}, 32'd0);
        @(negedge clk);
        chk("cmd_ready_back", {31'b0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ctrl", {26'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout,
                         bus.psel, bus.penable}, 32'd0);
        chk("rst_pwrite", {31'b0, bus.pwrite}, 32'd0);
        chk("rst_paddr", bus.paddr, 32'd0);
        chk("rst_pwdata", bus.pwdata, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", {31'b0, bus.cmd_ready}, 32'd1);

        // write then read, zero wait
        run_txn(1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0, 32'h0BADF00D, 0);
        run_txn(1'b0, 32'd5, 32'h11111111, 0, 1'b0, 32'hDEADBEEF, 0);
        // four wait states
        run_txn(1'b0, 32'd9, 32'h22222222, 4, 1'b0, 32'hCAFE0001, 0);
        // slave error
        run_txn(1'b0, 32'd40, 32'h0, 0, 1'b1, 32'h12345678, 0);
        // timeout, then pready landing on the last allowed ACCESS cycle
        run_txn(1'b0, 32'd7, 32'h0, TMO + 3, 1'b0, 32'hAAAA5555, 0);
        run_txn(1'b1, 32'd7, 32'h33333333, TMO, 1'b0, 32'h0, 0);
        run_txn(1'b0, 32'd7, 32'h0, TMO - 1, 1'b0, 32'h5555AAAA, 0);
        // response backpressure
        run_txn(1'b0, 32'd3, 32'h0, 1, 1'b0, 32'h76543210, 5);

        for (int i = 0; i < 30; i++) begin
            run_txn(1'($urandom), $urandom, $urandom, int'($urandom_range(0, TMO + 2)),
                    1'($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
        end

        // reset during an ACCESS wait state
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h0000_0100;
        bus.cmd_wdata = 32'hFEEDFACE;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'b0;
        @(negedge clk);
        chk("pre_rst_access", {30'b0, bus.psel, bus.penable}, 32'b11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctrl", {28'b0, bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, 32'd0);
        chk("mid_rst_paddr", bus.paddr, 32'd0);
        chk("mid_rst_pwdata", bus.pwdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_stale_rsp", {30'b0, bus.rsp_valid, bus.psel}, 32'd0);
        end
        run_txn(1'b0, 32'd12, 32'h0, 2, 1'b0, 32'h600DCAFE, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
